pb_number_entry: RTL and testbench

- User-input front end for the DE10 board: turns the four push buttons into an editable hex number of NUM_DIGITS digits, which is the input-side counterpart of the seven-segment display path.
- Each button is debounced and edge-detected. The number is edited one digit at a time under a cursor.
- Outputs a live value plus a blink enable mask, so ss_display shows which digit is selected.
- Outputs a committed value with a one-cycle strobe, for loading flex_counter or other consumers.

---
 rtl/pb_number_entry.sv | 120 ++++++++++++
 tb/tb_pb_number_entry.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pb_number_entry.sv
// Push-button hex number editor: debounced buttons edit digits under a
// blinking cursor and commit the value with a one-cycle strobe.
module pb_number_entry #(
   parameter int NUM_DIGITS      = 6,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BLINK_CYCLES    = 12500000,
   localparam int CURW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int NW   = 4 * NUM_DIGITS
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [3:0]      PB,
   output logic [NW-1:0]   number,
   output logic [CURW-1:0] cursor,
   output logic [NUM_DIGITS-1:0] en_mask,
   output logic [NW-1:0]   committed,
   output logic            commit_pulse
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [DW-1:0]   DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0]   BL_MAX  = BW'(BLINK_CYCLES - 1);
   localparam logic [CURW-1:0] CUR_MAX = CURW'(NUM_DIGITS - 1);

   logic [3:0]      db_q, db_d;
   logic [DW-1:0]   cnt_q [4];
   logic [DW-1:0]   cnt_d [4];
   logic [3:0]      press;
   logic [NW-1:0]   number_q, number_d;
   logic [NW-1:0]   committed_q, committed_d;
   logic            pulse_q, pulse_d;
   logic [CURW-1:0] cursor_q, cursor_d;
   logic [BW-1:0]   bl_q, bl_d;
   logic            phase_q, phase_d;
   logic [NUM_DIGITS-1:0] mask_q, mask_d;

   always_comb begin
      db_d        = db_q;
      number_d    = number_q;
      committed_d = committed_q;
      cursor_d    = cursor_q;
      bl_d        = bl_q;
      phase_d     = phase_q;
      mask_d      = '1;
      for (int k = 0; k < 4; k++) begin
         cnt_d[k] = '0;
         if (PB[k] != db_q[k]) begin
            if (cnt_q[k] == DB_MAX) begin
               db_d[k] = PB[k];
            end else begin
               cnt_d[k] = cnt_q[k] + DW'(1);
            end
         end
      end
      // A press is the debounced level falling 1->0 on this edge
      press = db_q & ~db_d;

      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (cursor_q == CURW'(d)) begin
            if (press[0] && !press[1]) begin
               number_d[4*d +: 4] = number_q[4*d +: 4] + 4'd1;
            end else if (press[1] && !press[0]) begin
               number_d[4*d +: 4] = number_q[4*d +: 4] - 4'd1;
            end
         end
      end

      if (press[2]) begin
         cursor_d = (cursor_q == CUR_MAX) ? '0 : cursor_q + CURW'(1);
         bl_d     = '0;
         phase_d  = 1'b1;
      end else if (bl_q == BL_MAX) begin
         bl_d    = '0;
         phase_d = ~phase_q;
      end else begin
         bl_d = bl_q + BW'(1);
      end

      for (int d = 0; d < NUM_DIGITS; d++) begin
         mask_d[d] = phase_d || (cursor_d != CURW'(d));
      end

      pulse_d = press[3];
      if (press[3]) begin
         committed_d = number_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         db_q        <= '1;
         cnt_q       <= '{default: '0};
         number_q    <= '0;
         committed_q <= '0;
         pulse_q     <= 1'b0;
         cursor_q    <= '0;
         bl_q        <= '0;
         phase_q     <= 1'b1;
         mask_q      <= '1;
      end else begin
         db_q        <= db_d;
         cnt_q       <= cnt_d;
         number_q    <= number_d;
         committed_q <= committed_d;
         pulse_q     <= pulse_d;
         cursor_q    <= cursor_d;
         bl_q        <= bl_d;
         phase_q     <= phase_d;
         mask_q      <= mask_d;
      end
   end

   assign number       = number_q;
   assign cursor       = cursor_q;
   assign en_mask      = mask_q;
   assign committed    = committed_q;
   assign commit_pulse = pulse_q;

endmodule

// File: tb/tb_pb_number_entry.sv
// Scoreboard bench for pb_number_entry: stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_pb_number_entry;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  PB  = 4'hF;
   logic [23:0] number;
   logic [2:0]  cursor;
   logic [5:0]  en_mask;
   logic [23:0] committed;
   logic        commit_pulse;

   pb_number_entry #(
      .NUM_DIGITS(6),
      .DEBOUNCE_CYCLES(4),
      .BLINK_CYCLES(8)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .PB(PB),
      .number(number),
      .cursor(cursor),
      .en_mask(en_mask),
      .committed(committed),
      .commit_pulse(commit_pulse)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic [23:0] num;
      logic [2:0]  cur;
      logic [5:0]  mask;
      logic        cm;
      logic [23:0] com;
      logic        pul;
   } snap_t;

   typedef struct {
      string       name;
      logic [23:0] val;
   } cexp_t;

   snap_t snap_q[$];
   cexp_t com_q[$];
   int    checks = 0;
   int    passed = 0;
   snap_t e;
   cexp_t c;

   always @(negedge CLK) begin
      while (snap_q.size() > 0) begin
         e = snap_q.pop_front();
         checks++;
         if (number !== e.num || cursor !== e.cur ||
             committed !== e.com || commit_pulse !== e.pul ||
             (e.cm && en_mask !== e.mask)) begin
            $display("FAIL %s: got num=%h cur=%0d mask=%h com=%h pulse=%b, want num=%h cur=%0d mask=%h(chk=%b) com=%h pulse=%b",
                     e.name, number, cursor, en_mask, committed, commit_pulse,
                     e.num, e.cur, e.mask, e.cm, e.com, e.pul);
         end else begin
            passed++;
         end
      end
      if (commit_pulse === 1'b1) begin
         checks++;
         if (com_q.size() == 0) begin
            $display("FAIL unexpected_commit: got committed=%h pulse=1, want no commit",
                     committed);
         end else begin
            c = com_q.pop_front();
            if (committed !== c.val) begin
               $display("FAIL %s: got committed=%h, want %h",
                        c.name, committed, c.val);
            end else begin
               passed++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string n, input logic [23:0] num,
                      input logic [2:0] cur, input logic [5:0] mask,
                      input logic cm, input logic [23:0] com,
                      input logic pul);
      snap_t s;
      s.name = n;
      s.num  = num;
      s.cur  = cur;
      s.mask = mask;
      s.cm   = cm;
      s.com  = com;
      s.pul  = pul;
      snap_q.push_back(s);
   endtask

   task automatic expect_commit(input string n, input logic [23:0] v);
      cexp_t x;
      x.name = n;
      x.val  = v;
      com_q.push_back(x);
   endtask

   task automatic press(input logic [3:0] lowm, input int n);
      PB = 4'hF & ~lowm;
      repeat (n) tick();
      PB = 4'hF;
      repeat (5) tick();
   endtask

   initial begin
      // reset with PB0 held: exactly one increment 4 edges after release
      PB  = 4'b1110;
      RST = 1'b1;
      tick();
      tick();
      chk("reset", 24'h0, 3'd0, 6'h3F, 1'b1, 24'h0, 1'b0);
      RST = 1'b0;
      repeat (3) tick();
      chk("hold_pre", 24'h0, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);
      tick();
      chk("hold_inc", 24'h1, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);
      repeat (6) tick();
      chk("hold_one", 24'h1, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);
      PB = 4'hF;
      repeat (5) tick();

      // debounce threshold
      PB = 4'b1110;
      repeat (3) tick();
      PB = 4'hF;
      repeat (5) tick();
      chk("deb_short", 24'h1, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);
      PB = 4'b1110;
      repeat (3) tick();
      chk("deb_3", 24'h1, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);
      tick();
      chk("deb_4", 24'h2, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);
      repeat (20) tick();
      chk("deb_hold", 24'h2, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);
      PB = 4'hF;
      repeat (5) tick();

      // digit wrap without carry
      repeat (13) press(4'b0001, 4);
      chk("wrap_f", 24'h00000F, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);
      press(4'b0001, 4);
      chk("wrap_inc", 24'h000000, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);
      press(4'b0010, 4);
      chk("wrap_dec", 24'h00000F, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);
      press(4'b0001, 4);
      chk("restore", 24'h000000, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);

      // cursor move restarts blink phase as on
      PB = 4'b1011;
      repeat (4) tick();
      chk("cur_move", 24'h0, 3'd1, 6'h3F, 1'b1, 24'h0, 1'b0);
      repeat (7) tick();
      chk("blink_on", 24'h0, 3'd1, 6'h3F, 1'b1, 24'h0, 1'b0);
      tick();
      chk("blink_off", 24'h0, 3'd1, 6'h3D, 1'b1, 24'h0, 1'b0);
      repeat (8) tick();
      chk("blink_back", 24'h0, 3'd1, 6'h3F, 1'b1, 24'h0, 1'b0);
      PB = 4'hF;
      repeat (5) tick();

      press(4'b0001, 4);
      press(4'b0001, 4);
      chk("cur_edit", 24'h000020, 3'd1, 6'h00, 1'b0, 24'h0, 1'b0);
      repeat (4) press(4'b0100, 4);
      chk("cur_five", 24'h000020, 3'd5, 6'h00, 1'b0, 24'h0, 1'b0);
      press(4'b0100, 4);
      chk("cur_wrap", 24'h000020, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);

      // simultaneous events
      press(4'b0011, 4);
      chk("inc_dec_cancel", 24'h000020, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);
      PB = 4'b0110;
      repeat (3) tick();
      expect_commit("commit_val", 24'h000021);
      tick();
      chk("commit_edge", 24'h000021, 3'd0, 6'h00, 1'b0, 24'h000021, 1'b1);
      tick();
      chk("commit_after", 24'h000021, 3'd0, 6'h00, 1'b0, 24'h000021, 1'b0);
      PB = 4'hF;
      repeat (5) tick();

      // glitch on commit button
      PB = 4'b0111;
      repeat (2) tick();
      PB = 4'hF;
      tick();
      PB = 4'b0111;
      repeat (2) tick();
      PB = 4'hF;
      repeat (5) tick();
      chk("glitch", 24'h000021, 3'd0, 6'h00, 1'b0, 24'h000021, 1'b0);

      // reset with commit count at 3, then 3 more low edges
      PB = 4'b0111;
      repeat (3) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      repeat (3) tick();
      PB = 4'hF;
      repeat (3) tick();
      chk("rst_mid", 24'h0, 3'd0, 6'h3F, 1'b1, 24'h0, 1'b0);
      repeat (5) tick();
      chk("rst_quiet", 24'h0, 3'd0, 6'h00, 1'b0, 24'h0, 1'b0);
      tick();

      checks++;
      if (com_q.size() != 0) begin
         $display("FAIL commit_drain: got %0d pending commits, want 0",
                  com_q.size());
      end else begin
         passed++;
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
